// File: rtl/wt_mem_sched_pkg.sv
// Shared types and constants for the write-through cache memory port scheduler.
package wt_mem_sched_pkg;

  // Return message types coming back from the memory adapter (value 3 is reserved).
  typedef enum logic [1:0] {
    IFILL     = 2'd0,
    DFILL     = 2'd1,
    STORE_ACK = 2'd2
  } rtrn_type_e;

  // Requester port indices on the shared memory port.
  localparam logic [1:0] PORT_IC = 2'd0;
  localparam logic [1:0] PORT_DC = 2'd1;
  localparam logic [1:0] PORT_WB = 2'd2;

  // Scheduler states: waiting to pick a requester, or holding an issued request.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sched_state_e;

  // Next port index in round-robin order, wrapping 2 back to 0.
  function automatic logic [1:0] nextPort(input logic [1:0] p);
    nextPort = (p >= PORT_WB) ? PORT_IC : (p + 2'd1);
  endfunction

endpackage

// File: rtl/wt_mem_port_sched_rr_arb3.sv
// Three-way round-robin pick: first request at or after the pointer wins.
module rr_arb3
  import wt_mem_sched_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] ptr_i,
  output logic       gnt_valid_o,
  output logic [1:0] gnt_idx_o
);

  logic [3:0] w_req;
  logic [1:0] w_c0;
  logic [1:0] w_c1;
  logic [1:0] w_c2;

  // Walk the three candidates in priority order starting from the pointer.
  always_comb begin
    w_req       = {1'b0, req_i};
    w_c0        = (ptr_i > PORT_WB) ? PORT_IC : ptr_i;
    w_c1        = nextPort(w_c0);
    w_c2        = nextPort(w_c1);
    gnt_valid_o = |req_i;
    gnt_idx_o   = w_c0;
    if (w_req[w_c0]) begin
      gnt_idx_o = w_c0;
    end else if (w_req[w_c1]) begin
      gnt_idx_o = w_c1;
    end else if (w_req[w_c2]) begin
      gnt_idx_o = w_c2;
    end
  end

endmodule

// File: rtl/wt_mem_port_sched.sv
// Memory request port scheduler shared by I$ refill, D$ refill/NC load and the write buffer.
module wt_mem_port_sched
  import wt_mem_sched_pkg::*;
#(
  parameter int PADDR_W        = 34,
  parameter int DATA_W         = 128,
  parameter int TID_W          = 2,
  parameter int MAX_OUT_STORES = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [2:0]             req_valid_i,
  output logic [2:0]             req_ready_o,
  input  logic [3*PADDR_W-1:0]   req_addr_i,
  input  logic [3*TID_W-1:0]     req_tid_i,
  input  logic [2:0]             req_nc_i,
  input  logic [DATA_W-1:0]      st_data_i,
  input  logic [DATA_W/8-1:0]    st_be_i,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [1:0]             mem_req_port_o,
  output logic [PADDR_W-1:0]     mem_req_addr_o,
  output logic [TID_W-1:0]       mem_req_tid_o,
  output logic                   mem_req_nc_o,
  output logic [DATA_W-1:0]      mem_req_data_o,
  output logic [DATA_W/8-1:0]    mem_req_be_o,
  input  logic                   mem_rtrn_valid_i,
  input  logic [1:0]             mem_rtrn_type_i,
  output logic [2:0]             mem_rtrn_valid_o,
  output logic                   stores_pending_o,
  output logic                   err_o
);

  localparam int CNT_W = $clog2(MAX_OUT_STORES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT_STORES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  sched_state_e          r_state;
  sched_state_e          w_state_nxt;
  logic [1:0]            r_rr_ptr;
  logic [CNT_W-1:0]      r_st_cnt;
  logic                  r_err;
  logic [1:0]            r_port;
  logic [PADDR_W-1:0]    r_addr;
  logic [TID_W-1:0]      r_tid;
  logic                  r_nc;
  logic [DATA_W-1:0]     r_data;
  logic [DATA_W/8-1:0]   r_be;

  logic                  w_cnt_nz;
  logic [2:0]            w_mask;
  logic [2:0]            w_eligible;
  logic                  w_gnt_valid;
  logic [1:0]            w_gnt_idx;
  logic                  w_issue;
  logic                  w_accept;
  logic                  w_st_inc;
  logic                  w_st_ack;
  logic                  w_rsvd_rtrn;
  logic [PADDR_W-1:0]    w_sel_addr;
  logic [TID_W-1:0]      w_sel_tid;
  logic                  w_sel_nc;

  // Stores are capped by the counter; NC loads wait until every store has been acknowledged.
  always_comb begin
    w_cnt_nz   = (r_st_cnt != '0);
    w_mask     = {(r_st_cnt == CNT_MAX), (req_nc_i[1] & w_cnt_nz), 1'b0};
    w_eligible = req_valid_i & ~w_mask;
  end

  rr_arb3 u_arb (
    .req_i       (w_eligible),
    .ptr_i       (r_rr_ptr),
    .gnt_valid_o (w_gnt_valid),
    .gnt_idx_o   (w_gnt_idx)
  );

  // Select the winning requester's address, ID and NC flag for capture.
  always_comb begin
    w_sel_addr = req_addr_i[PADDR_W-1:0];
    w_sel_tid  = req_tid_i[TID_W-1:0];
    w_sel_nc   = req_nc_i[0];
    case (w_gnt_idx)
      PORT_DC: begin
        w_sel_addr = req_addr_i[2*PADDR_W-1:PADDR_W];
        w_sel_tid  = req_tid_i[2*TID_W-1:TID_W];
        w_sel_nc   = req_nc_i[1];
      end
      PORT_WB: begin
        w_sel_addr = req_addr_i[3*PADDR_W-1:2*PADDR_W];
        w_sel_tid  = req_tid_i[3*TID_W-1:2*TID_W];
        w_sel_nc   = req_nc_i[2];
      end
      default: begin
        w_sel_addr = req_addr_i[PADDR_W-1:0];
        w_sel_tid  = req_tid_i[TID_W-1:0];
        w_sel_nc   = req_nc_i[0];
      end
    endcase
  end

  // Scheduler state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: issue from IDLE when something is eligible, return to IDLE once accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_issue     = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (mem_req_ready_i) begin
          w_accept    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Capture the granted request; it stays frozen through HOLD regardless of the requester.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_port <= '0;
      r_addr <= '0;
      r_tid  <= '0;
      r_nc   <= 1'b0;
      r_data <= '0;
      r_be   <= '0;
    end else if (w_issue) begin
      r_port <= w_gnt_idx;
      r_addr <= w_sel_addr;
      r_tid  <= w_sel_tid;
      r_nc   <= w_sel_nc;
      r_data <= (w_gnt_idx == PORT_WB) ? st_data_i : '0;
      r_be   <= (w_gnt_idx == PORT_WB) ? st_be_i : '0;
    end
  end

  // Advance the round-robin pointer past the port whose request was just accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= PORT_IC;
    end else if (w_accept) begin
      r_rr_ptr <= nextPort(r_port);
    end
  end

  // Store handshake and store acknowledge events.
  always_comb begin
    w_st_inc    = w_accept & (r_port == PORT_WB);
    w_st_ack    = mem_rtrn_valid_i & (mem_rtrn_type_i == STORE_ACK);
    w_rsvd_rtrn = mem_rtrn_valid_i & (mem_rtrn_type_i == 2'd3);
  end

  // Outstanding store counter; a simultaneous issue and ack cancel out, and it never underflows.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_st_cnt <= '0;
    end else if (w_st_inc && !w_st_ack) begin
      r_st_cnt <= r_st_cnt + CNT_ONE;
    end else if (!w_st_inc && w_st_ack && w_cnt_nz) begin
      r_st_cnt <= r_st_cnt - CNT_ONE;
    end
  end

  // Sticky protocol error: spurious store ack or reserved return type.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if ((w_st_ack && !w_cnt_nz) || w_rsvd_rtrn) begin
      r_err <= 1'b1;
    end
  end

  // Route each return to its owner by type; reserved types go nowhere.
  always_comb begin
    mem_rtrn_valid_o = 3'b000;
    if (mem_rtrn_valid_i) begin
      case (mem_rtrn_type_i)
        IFILL:     mem_rtrn_valid_o = 3'b001;
        DFILL:     mem_rtrn_valid_o = 3'b010;
        STORE_ACK: mem_rtrn_valid_o = 3'b100;
        default:   mem_rtrn_valid_o = 3'b000;
      endcase
    end
  end

  // Drive request-side outputs from the held payload; acceptance pulse is one-hot on the owner.
  always_comb begin
    mem_req_valid_o  = (r_state == HOLD);
    mem_req_port_o   = r_port;
    mem_req_addr_o   = r_addr;
    mem_req_tid_o    = r_tid;
    mem_req_nc_o     = r_nc;
    mem_req_data_o   = r_data;
    mem_req_be_o     = r_be;
    req_ready_o      = w_accept ? (3'b001 << r_port) : 3'b000;
    stores_pending_o = w_cnt_nz;
    err_o            = r_err;
  end

endmodule
